adc_spi_config: RTL and testbench
=================================

# adc_spi_config

Serial-port configuration controller for the BeScope ADC. It accepts single-register read/write commands from the Avalon-side register logic and drives the ADC 3-wire SPI pins ADC_CSBn, ADC_SCLK and ADC_SDIO. It generates the 24-bit instruction/data frame and SCLK from main_clk, and returns read data. It sits between the memory-mapped control registers and the ADC pins, replacing the static CSBn/SCLK tie-offs.

## Interface
- CLK_DIV, 4: main_clk cycles per SCLK half-period; legal range 1..255.
- CS_GAP, 4: minimum main_clk cycles with CSBn high between frames; legal range 1..255.
- main_clk  in  1  system clock; all logic is on its rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- start  in  1  command strobe; sampled only in IDLE.
- rw  in  1  1 = read, 0 = write; latched with start.
- reg_addr  in  13  ADC register address; latched with start.
- wr_data  in  8  write payload; latched with start and ignored for reads.
- busy  out  1  high from the cycle after accept until the transaction ends.
- done  out  1  one-cycle pulse at transaction end.
- rd_data  out  8  last read result; held until the next read completes.
- spi_csb_n  out  1  ADC_CSBn.
- spi_sclk  out  1  ADC_SCLK; idles low.
- sdio_out  out  1  SDIO drive value.
- sdio_oe  out  1  SDIO output enable; the top level builds the tristate.
- sdio_in  in  1  SDIO pad input.

## Operation
- Frame is 24 bits, MSB first: bit23 = rw, bits 22:21 = 2'b00 (one byte), bits 20:8 = reg_addr, bits 7:0 = wr_data for writes or 0 for reads.
- States:
  - IDLE: accept when start=1.
  - SETUP: CSBn low, SCLK low, CLK_DIV cycles.
  - SHIFT: 24 bits. Each bit is CLK_DIV cycles SCLK low, then CLK_DIV cycles SCLK high.
  - HOLD: SCLK low, CLK_DIV cycles.
  - GAP: CSBn high, CS_GAP cycles.
  - Then back to IDLE.
- sdio_out changes only at the start of an SCLK-low phase and is stable at each rising edge.
- Write: sdio_oe=1 for SETUP through HOLD.
- Read: sdio_oe=1 for bits 23..8. sdio_oe drops at the start of the low phase of bit 7 and stays 0 through GAP. sdio_in is sampled on the main_clk cycle where spi_sclk goes 0→1 for bits 7..0. rd_data updates on the done cycle.
- Command inputs are latched on accept; changes while busy have no effect.
- start while busy is ignored, not queued.
- start on the done cycle is ignored; it is accepted on the next cycle if still high.
- Reset values, immediate on rst_n low including mid-frame: spi_csb_n=1, spi_sclk=0, sdio_out=0, sdio_oe=0, busy=0, done=0, rd_data=0, state=IDLE.
- A frame aborted by reset produces no done pulse and leaves rd_data at 0.

## Timing
- Accept at cycle T (start=1 in IDLE).
- At T+1: busy=1, spi_csb_n=0, sdio_oe=1, sdio_out=bit23.
- First SCLK rising edge at T+1+2·CLK_DIV.
- 24 rising edges per frame, with period 2·CLK_DIV.
- spi_csb_n rises at T+1+50·CLK_DIV.
- done=1 and busy=0 at T+1+50·CLK_DIV+CS_GAP; for the defaults this is T+205.
- The counters behind spi_sclk, sdio_out and spi_csb_n are all registered, so no output glitches.
- Bit and phase counters must not wrap: the bit counter is 5 bits and stops at 24; the half-period counter reloads at CLK_DIV-1.

## Structure
- Package adc_spi_pkg holds:
  - the state enum (IDLE, SETUP, SHIFT, HOLD, GAP);
  - FRAME_BITS=24, ADDR_W=13, DATA_W=8;
  - field position constants;
  - the W1:W0 constant 2'b00.
- Sub-module adc_spi_tick: a half-period counter emitting a one-cycle tick every CLK_DIV cycles while enabled; cleared on disable and on reset.
- The top-level SDIO tristate stays outside this block.

## Test plan
- Write, defaults, reg_addr=0x014, wr_data=0x41 -> SPI monitor captures 0x001441 on 24 rising edges; sdio_oe=1 throughout; done at T+205.
- Read reg_addr=0x001 with an ADC model driving 0x8A on bits 7..0 -> header 0x8001 captured; sdio_oe=0 during the last 8 bits; rd_data=0x8A on done.
- start pulsed at T+50 during a write -> ignored; exactly one frame and one done pulse.
- Two different commands issued back-to-back, start held high -> spi_csb_n high for at least CS_GAP+1 cycles between frames; both frames correct.
- rst_n low at bit 10 of a read -> all outputs return to their reset values asynchronously; no done pulse; a following write completes normally.
- CLK_DIV=1, CS_GAP=1, write 0x1FFF/0xFF -> 0x1FFFFF captured; done at T+52.

Source files
------------

// File: rtl/adc_spi_pkg.sv
// Shared types and frame layout for the ADC 3-wire SPI configuration port.
package adc_spi_pkg;

  localparam int unsigned FRAME_BITS = 24;
  localparam int unsigned ADDR_W     = 13;
  localparam int unsigned DATA_W     = 8;
  localparam int unsigned BIT_CNT_W  = 5;
  localparam int unsigned DIV_W      = 8;

  // Frame field positions, MSB first on the wire.
  localparam int unsigned RW_POS   = 23;
  localparam int unsigned W_MSB    = 22;
  localparam int unsigned W_LSB    = 21;
  localparam int unsigned ADDR_MSB = 20;
  localparam int unsigned ADDR_LSB = 8;
  localparam int unsigned DATA_MSB = 7;
  localparam int unsigned DATA_LSB = 0;

  // Number of frame bits driven by the controller before read data starts.
  localparam int unsigned RD_FIRST_BIT = FRAME_BITS - DATA_W;

  // W1:W0 transfer length field: single byte.
  localparam logic [W_MSB-W_LSB:0] W_ONE_BYTE = 2'b00;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    GAP
  } state_e;

  typedef struct packed {
    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } cmd_t;

  // Assemble the instruction/data frame; reads send zeros in the data byte.
  function automatic logic [FRAME_BITS-1:0] build_frame(input cmd_t cmd);
    return {cmd.rw, W_ONE_BYTE, cmd.addr, cmd.rw ? DATA_W'(0) : cmd.data};
  endfunction

endpackage

// File: rtl/adc_spi_tick.sv
// Half-period timer: one-cycle tick every CLK_DIV cycles while enabled.
module adc_spi_tick
  import adc_spi_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick_c
);

  localparam logic [DIV_W-1:0] RELOAD = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] cnt_q;

  // Down-counter reloads on disable and after each tick, so it never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= RELOAD;
    end else if (!en || (cnt_q == '0)) begin
      cnt_q <= RELOAD;
    end else begin
      cnt_q <= cnt_q - DIV_W'(1);
    end
  end

  assign tick_c = en && (cnt_q == '0);

endmodule

// File: rtl/adc_spi_config.sv
// ADC serial-port controller: one 24-bit register read/write per start strobe.
module adc_spi_config
  import adc_spi_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned CS_GAP  = 4
) (
  input  logic              main_clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              rw,
  input  logic [ADDR_W-1:0] reg_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rd_data,
  output logic              spi_csb_n,
  output logic              spi_sclk,
  output logic              sdio_out,
  output logic              sdio_oe,
  input  logic              sdio_in
);

  state_e                state_q, state_d;
  logic                  rw_q, rw_d;
  logic [FRAME_BITS-1:0] tx_q, tx_d;
  logic [BIT_CNT_W-1:0]  bit_q, bit_d;
  logic [DIV_W-1:0]      gap_q, gap_d;
  logic [DATA_W-1:0]     rx_q, rx_d;
  logic [DATA_W-1:0]     rd_data_d;
  logic                  busy_d, done_d, csb_d, sclk_d, sdo_d, oe_d;
  logic                  tick_en_c, tick_c;
  cmd_t                  cmd_c;
  logic [FRAME_BITS-1:0] frame_c;

  assign cmd_c     = '{rw: rw, addr: reg_addr, data: wr_data};
  assign frame_c   = build_frame(cmd_c);
  assign tick_en_c = (state_q == SETUP) || (state_q == SHIFT) || (state_q == HOLD);

  adc_spi_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .clk    (main_clk),
    .rst_n  (rst_n),
    .en     (tick_en_c),
    .tick_c (tick_c)
  );

  // State register.
  always_ff @(posedge main_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and next-output logic; every pin is driven from a register.
  always_comb begin
    state_d   = state_q;
    rw_d      = rw_q;
    tx_d      = tx_q;
    bit_d     = bit_q;
    gap_d     = gap_q;
    rx_d      = rx_q;
    rd_data_d = rd_data;
    busy_d    = busy;
    done_d    = 1'b0;
    csb_d     = spi_csb_n;
    sclk_d    = spi_sclk;
    sdo_d     = sdio_out;
    oe_d      = sdio_oe;

    case (state_q)
      IDLE: begin
        // A start coinciding with the done pulse waits one more cycle.
        if (start && !done) begin
          state_d = SETUP;
          rw_d    = cmd_c.rw;
          tx_d    = {frame_c[FRAME_BITS-2:0], 1'b0};
          sdo_d   = frame_c[RW_POS];
          bit_d   = '0;
          gap_d   = '0;
          rx_d    = '0;
          busy_d  = 1'b1;
          csb_d   = 1'b0;
          sclk_d  = 1'b0;
          oe_d    = 1'b1;
        end
      end

      SETUP: begin
        if (tick_c) begin
          state_d = SHIFT;
        end
      end

      SHIFT: begin
        if (tick_c) begin
          if (!spi_sclk) begin
            // Rising SCLK: capture the ADC's read bit driven during the low phase.
            sclk_d = 1'b1;
            if (rw_q && (bit_q >= BIT_CNT_W'(RD_FIRST_BIT))) begin
              rx_d = {rx_q[DATA_W-2:0], sdio_in};
            end
          end else begin
            // Falling SCLK: bit complete, present the next one.
            sclk_d = 1'b0;
            bit_d  = bit_q + BIT_CNT_W'(1);
            if (bit_q == BIT_CNT_W'(FRAME_BITS - 1)) begin
              state_d = HOLD;
              sdo_d   = 1'b0;
            end else begin
              sdo_d = tx_q[FRAME_BITS-1];
              tx_d  = {tx_q[FRAME_BITS-2:0], 1'b0};
              if (rw_q && (bit_q == BIT_CNT_W'(RD_FIRST_BIT - 1))) begin
                oe_d = 1'b0;
              end
            end
          end
        end
      end

      HOLD: begin
        if (tick_c) begin
          state_d = GAP;
          csb_d   = 1'b1;
          oe_d    = 1'b0;
          gap_d   = '0;
        end
      end

      GAP: begin
        if (gap_q == DIV_W'(CS_GAP - 1)) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          if (rw_q) begin
            rd_data_d = rx_q;
          end
        end else begin
          gap_d = gap_q + DIV_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge main_clk or negedge rst_n) begin
    if (!rst_n) begin
      rw_q      <= 1'b0;
      tx_q      <= '0;
      bit_q     <= '0;
      gap_q     <= '0;
      rx_q      <= '0;
      rd_data   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      spi_csb_n <= 1'b1;
      spi_sclk  <= 1'b0;
      sdio_out  <= 1'b0;
      sdio_oe   <= 1'b0;
    end else begin
      rw_q      <= rw_d;
      tx_q      <= tx_d;
      bit_q     <= bit_d;
      gap_q     <= gap_d;
      rx_q      <= rx_d;
      rd_data   <= rd_data_d;
      busy      <= busy_d;
      done      <= done_d;
      spi_csb_n <= csb_d;
      spi_sclk  <= sclk_d;
      sdio_out  <= sdo_d;
      sdio_oe   <= oe_d;
    end
  end

endmodule

// File: tb/tb_adc_spi_config.sv
// Bench for adc_spi_config: cycle model of the pin waveforms plus an ADC/SPI monitor.
module tb_adc_spi_config;

  localparam int NDUT = 2;

  logic        main_clk = 1'b0;
  logic        rst_n    = 1'b1;
  logic        start     [NDUT];
  logic        rw        [NDUT];
  logic [12:0] reg_addr  [NDUT];
  logic [7:0]  wr_data   [NDUT];
  logic        sdio_in   [NDUT];
  logic        busy      [NDUT];
  logic        done      [NDUT];
  logic [7:0]  rd_data   [NDUT];
  logic        spi_csb_n [NDUT];
  logic        spi_sclk  [NDUT];
  logic        sdio_out  [NDUT];
  logic        sdio_oe   [NDUT];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Model / monitor state per instance.
  logic        m_valid [NDUT];
  int          m_t     [NDUT];
  logic        m_rw    [NDUT];
  logic [23:0] m_frame [NDUT];
  logic [7:0]  m_rd    [NDUT];
  logic [7:0]  adc     [NDUT];
  logic        p_sclk  [NDUT];
  logic        p_csb   [NDUT];
  logic [23:0] cap     [NDUT];
  logic [23:0] last_cap[NDUT];
  int          rises   [NDUT];
  int          run     [NDUT];
  logic        had_frm [NDUT];
  int          dcount  [NDUT];
  int          lat     [NDUT];

  always #5 main_clk = ~main_clk;

  adc_spi_config #(.CLK_DIV(4), .CS_GAP(4)) u_dut (
    .main_clk (main_clk),    .rst_n    (rst_n),
    .start    (start[0]),    .rw       (rw[0]),
    .reg_addr (reg_addr[0]), .wr_data  (wr_data[0]),
    .busy     (busy[0]),     .done     (done[0]),
    .rd_data  (rd_data[0]),  .spi_csb_n(spi_csb_n[0]),
    .spi_sclk (spi_sclk[0]), .sdio_out (sdio_out[0]),
    .sdio_oe  (sdio_oe[0]),  .sdio_in  (sdio_in[0])
  );

  adc_spi_config #(.CLK_DIV(1), .CS_GAP(1)) u_dut_fast (
    .main_clk (main_clk),    .rst_n    (rst_n),
    .start    (start[1]),    .rw       (rw[1]),
    .reg_addr (reg_addr[1]), .wr_data  (wr_data[1]),
    .busy     (busy[1]),     .done     (done[1]),
    .rd_data  (rd_data[1]),  .spi_csb_n(spi_csb_n[1]),
    .spi_sclk (spi_sclk[1]), .sdio_out (sdio_out[1]),
    .sdio_oe  (sdio_oe[1]),  .sdio_in  (sdio_in[1])
  );

  function automatic int cd_of(input int i);
    return (i == 0) ? 4 : 1;
  endfunction

  function automatic int gap_of(input int i);
    return (i == 0) ? 4 : 1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the timing model, plus SPI monitor and ADC responder.
  always @(negedge main_clk) begin
    cyc++;
    for (int i = 0; i < NDUT; i++) begin
      int   cd, gp, dk, k, j, b;
      logic in_t, e_busy, e_done, e_csb, e_sclk, e_oe;
      cd = cd_of(i);
      gp = gap_of(i);
      dk = 50 * cd + gp + 1;
      if (!rst_n) begin
        chk("reset_outs",
            32'({busy[i], done[i], spi_csb_n[i], spi_sclk[i], sdio_out[i], sdio_oe[i], rd_data[i]}),
            32'({1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00}));
        m_valid[i] = 1'b0;
        m_rd[i]    = 8'h00;
        p_sclk[i]  = 1'b0;
        p_csb[i]   = 1'b1;
        sdio_in[i] = 1'b0;
        had_frm[i] = 1'b0;
        rises[i]   = 0;
        run[i]     = 0;
      end else begin
        k    = cyc - m_t[i];
        in_t = m_valid[i] && (k >= 1) && (k <= dk);
        j    = k - 1 - cd;
        e_busy = in_t && (k < dk);
        e_done = in_t && (k == dk);
        e_csb  = !(in_t && (k <= 50 * cd));
        e_sclk = in_t && (j >= 0) && (j < 48 * cd) && ((j % (2 * cd)) >= cd);
        e_oe   = in_t && (k <= (m_rw[i] ? 33 * cd : 50 * cd));
        if (e_done && m_rw[i]) m_rd[i] = adc[i];
        chk("pins", 32'({busy[i], done[i], spi_csb_n[i], spi_sclk[i], sdio_oe[i]}),
            32'({e_busy, e_done, e_csb, e_sclk, e_oe}));
        chk("rd_data", 32'(rd_data[i]), 32'(m_rd[i]));
        if (e_oe && (k <= 49 * cd)) begin
          b = (j < 0) ? 0 : j / (2 * cd);
          chk("sdio_out", 32'(sdio_out[i]), 32'(m_frame[i][23 - b]));
        end
        if (done[i]) begin
          dcount[i]++;
          lat[i] = cyc - m_t[i];
        end
        // SPI monitor: bus value on each SCLK rising edge.
        if (!p_sclk[i] && spi_sclk[i]) begin
          cap[i] = {cap[i][22:0], sdio_oe[i] ? sdio_out[i] : sdio_in[i]};
          rises[i]++;
        end
        // ADC responder: drives read data after SCLK falls, once the controller releases SDIO.
        if (p_sclk[i] && !spi_sclk[i] && !sdio_oe[i] && (rises[i] >= 16) && (rises[i] < 24))
          sdio_in[i] = adc[i][23 - rises[i]];
        if (p_csb[i] && !spi_csb_n[i]) begin
          if (had_frm[i]) chk("cs_gap", 32'(run[i] >= gp + 1), 32'd1);
          cap[i]   = 24'h0;
          rises[i] = 0;
          run[i]   = 0;
        end
        if (!p_csb[i] && spi_csb_n[i]) begin
          chk("frame", 32'(cap[i]), 32'(m_frame[i]));
          chk("rises", 32'(rises[i]), 32'd24);
          last_cap[i] = cap[i];
          had_frm[i]  = 1'b1;
          sdio_in[i]  = 1'b0;
          run[i]      = 0;
        end
        if (spi_csb_n[i]) run[i]++;
        p_sclk[i] = spi_sclk[i];
        p_csb[i]  = spi_csb_n[i];
        // Acceptance: idle and not on the done cycle.
        if (!(m_valid[i] && (k <= dk)) && start[i]) begin
          m_valid[i] = 1'b1;
          m_t[i]     = cyc;
          m_rw[i]    = rw[i];
          m_frame[i] = {rw[i], 2'b00, reg_addr[i], rw[i] ? adc[i] : wr_data[i]};
        end
      end
    end
  end

  task automatic issue(input int i, input logic r, input logic [12:0] a, input logic [7:0] d);
    @(posedge main_clk); #1;
    start[i] = 1'b1; rw[i] = r; reg_addr[i] = a; wr_data[i] = d;
    @(posedge main_clk); #1;
    start[i] = 1'b0;
  endtask

  task automatic wait_done(input int i, input string name);
    int c0;
    int n;
    c0 = dcount[i];
    n  = 0;
    while ((dcount[i] == c0) && (n < 2000)) begin
      @(posedge main_clk);
      n++;
    end
    chk(name, 32'(dcount[i] != c0), 32'd1);
  endtask

  task automatic wait_busy(input int i, input string name);
    int n;
    n = 0;
    while (!busy[i] && (n < 50)) begin
      @(posedge main_clk); #1;
      n++;
    end
    chk(name, 32'(busy[i]), 32'd1);
  endtask

  initial begin
    int c0;
    int n;
    for (int i = 0; i < NDUT; i++) begin
      start[i] = 1'b0; rw[i] = 1'b0; reg_addr[i] = '0; wr_data[i] = '0;
      adc[i] = 8'h00; dcount[i] = 0; lat[i] = 0; m_valid[i] = 1'b0; m_t[i] = 0;
      m_rw[i] = 1'b0; m_frame[i] = '0; m_rd[i] = '0; cap[i] = '0; last_cap[i] = '0;
      p_sclk[i] = 1'b0; p_csb[i] = 1'b1; rises[i] = 0; run[i] = 0; had_frm[i] = 1'b0;
      sdio_in[i] = 1'b0;
    end
    #2 rst_n = 1'b0;
    repeat (3) @(posedge main_clk);
    #2 rst_n = 1'b1;
    repeat (2) @(posedge main_clk);

    // Plain write with default timing.
    issue(0, 1'b0, 13'h014, 8'h41);
    wait_done(0, "wr1_done");
    chk("wr1_frame", 32'(last_cap[0]), 32'h001441);
    chk("wr1_latency", 32'(lat[0]), 32'd205);

    // Read with ADC returning 0x8A.
    adc[0] = 8'h8A;
    issue(0, 1'b1, 13'h001, 8'h55);
    wait_done(0, "rd1_done");
    #1;
    chk("rd1_frame", 32'(last_cap[0]), 32'h80018A);
    chk("rd1_data", 32'(rd_data[0]), 32'h8A);

    // Second start while busy is dropped.
    c0 = dcount[0];
    issue(0, 1'b0, 13'h0F0, 8'h3C);
    repeat (48) @(posedge main_clk);
    #1 start[0] = 1'b1; rw[0] = 1'b1; reg_addr[0] = 13'h1AA;
    @(posedge main_clk); #1 start[0] = 1'b0;
    wait_done(0, "ign_done");
    repeat (250) @(posedge main_clk);
    chk("ign_one_done", 32'(dcount[0] - c0), 32'd1);
    chk("ign_frame", 32'(last_cap[0]), 32'h00F03C);

    // Back-to-back with start held: write then read.
    adc[0] = 8'h3C;
    @(posedge main_clk); #1;
    start[0] = 1'b1; rw[0] = 1'b0; reg_addr[0] = 13'h0AB; wr_data[0] = 8'h5C;
    wait_busy(0, "b2b_busy_a");
    rw[0] = 1'b1; reg_addr[0] = 13'h1234; wr_data[0] = 8'hEE;
    wait_done(0, "b2b_done_a");
    chk("b2b_frame_a", 32'(last_cap[0]), 32'h00AB5C);
    @(posedge main_clk); #1;
    wait_busy(0, "b2b_busy_b");
    start[0] = 1'b0;
    wait_done(0, "b2b_done_b");
    #1;
    chk("b2b_frame_b", 32'(last_cap[0]), 32'h92343C);
    chk("b2b_rd_data", 32'(rd_data[0]), 32'h3C);

    // Reset during bit 10 of a read.
    adc[0] = 8'h77;
    c0 = dcount[0];
    issue(0, 1'b1, 13'h0C3, 8'h00);
    n = 0;
    while ((rises[0] < 14) && (n < 1000)) begin
      @(posedge main_clk);
      n++;
    end
    chk("abort_reached_bit10", 32'(rises[0] >= 14), 32'd1);
    #3 rst_n = 1'b0;
    #1;
    chk("abort_async_outs",
        32'({busy[0], done[0], spi_csb_n[0], spi_sclk[0], sdio_out[0], sdio_oe[0], rd_data[0]}),
        32'({1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00}));
    repeat (3) @(posedge main_clk);
    #2 rst_n = 1'b1;
    repeat (300) @(posedge main_clk);
    chk("abort_no_done", 32'(dcount[0] - c0), 32'd0);
    issue(0, 1'b0, 13'h055, 8'hA5);
    wait_done(0, "post_rst_done");
    chk("post_rst_frame", 32'(last_cap[0]), 32'h0055A5);

    // Fastest timing on the second instance.
    issue(1, 1'b0, 13'h1FFF, 8'hFF);
    wait_done(1, "fast_done");
    chk("fast_frame", 32'(last_cap[1]), 32'h1FFFFF);
    chk("fast_latency", 32'(lat[1]), 32'd52);

    repeat (10) @(posedge main_clk);
    chk("done_count_0", 32'(dcount[0]), 32'd6);
    chk("done_count_1", 32'(dcount[1]), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
